// File: rtl/reg_wr_arb_rr.sv
// Round-robin write arbiter for the register bank write port.
// One-entry output stage; drain and refill can share one edge.
module reg_wr_arb_rr #(
  parameter  int REQ_NUM    = 4,
  parameter  int ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_WIDTH   = $clog2(REQ_NUM)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [REQ_NUM-1:0]            i_req_valid,
  output logic [REQ_NUM-1:0]            o_req_ready,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_data,
  input  logic                          i_wr_ready,
  output logic                          o_wr_en,
  output logic [ADDR_WIDTH-1:0]         o_wr_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [ID_WIDTH-1:0]           o_wr_id
);

  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ID_WIDTH-1:0]   r_wr_id;
  logic [ID_WIDTH-1:0]   r_ptr;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win;
  logic [ID_WIDTH-1:0]   w_next_ptr;
  logic                  w_free;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      j = int'(r_ptr) + i;
      if (j >= REQ_NUM) j = j - REQ_NUM;
      if (!w_found && i_req_valid[j]) begin
        w_found = 1'b1;
        w_win   = ID_WIDTH'(j);
      end
    end
  end

  always_comb begin
    if (int'(w_win) == REQ_NUM - 1) w_next_ptr = '0;
    else                             w_next_ptr = w_win + 1'b1;
  end

  assign w_free  = !r_wr_en || i_wr_ready;
  assign w_grant = w_found && w_free && !i_rst;
  assign w_addr  = i_req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_data  = i_req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    o_req_ready = '0;
    if (w_grant) o_req_ready[w_win] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_id   <= '0;
      r_ptr     <= '0;
    end else if (w_grant) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= w_addr;
      r_wr_data <= w_data;
      r_wr_id   <= w_win;
      r_ptr     <= w_next_ptr;
    end else if (r_wr_en && i_wr_ready) begin
      r_wr_en   <= 1'b0;
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_wr_id   = r_wr_id;

endmodule

// File: tb/tb_reg_wr_arb_rr.sv
// Directed bench for reg_wr_arb_rr: vector table plus
// hand sequences for async reset and back-to-back writes.
module tb_reg_wr_arb_rr;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [19:0] req_addr;
  logic [127:0] req_data;
  logic        wr_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_id;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0]  a_tab [4];
  logic [31:0] d_tab [4];

  typedef struct {
    logic [3:0] v;
    logic       wr;
    logic [3:0] rdy;
    logic       en;
    logic [1:0] id;
  } vec_t;

  vec_t tv [21];

  reg_wr_arb_rr dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .i_wr_ready  (wr_ready),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_wr_id     (wr_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v,
                              input logic wr,
                              input logic [3:0] rdy,
                              input logic en,
                              input logic [1:0] id);
    vec_t t;
    t.v = v; t.wr = wr; t.rdy = rdy;
    t.en = en; t.id = id;
    return t;
  endfunction

  task automatic load_tab();
    for (int k = 0; k < 4; k++) begin
      req_addr[k*5 +: 5]   = a_tab[k];
      req_data[k*32 +: 32] = d_tab[k];
    end
  endtask

  task automatic chk_out(input string nm,
                         input logic en,
                         input logic [1:0] id);
    chk({nm, ".en"}, 32'(wr_en), 32'(en));
    chk({nm, ".id"}, 32'(wr_id), 32'(id));
    chk({nm, ".addr"}, 32'(wr_addr), 32'(a_tab[id]));
    chk({nm, ".data"}, wr_data, d_tab[id]);
  endtask

  initial begin
    a_tab[0] = 5'd1;  d_tab[0] = 32'h0000_00A0;
    a_tab[1] = 5'd2;  d_tab[1] = 32'h0000_00B1;
    a_tab[2] = 5'd5;  d_tab[2] = 32'hDEAD_BEEF;
    a_tab[3] = 5'd7;  d_tab[3] = 32'h0000_00C3;

    // single request, drain, then full rotation from ptr=3
    tv[0]  = mk(4'b0100, 1, 4'b0100, 1, 2);
    tv[1]  = mk(4'b0000, 1, 4'b0000, 0, 2);
    tv[2]  = mk(4'b1111, 1, 4'b1000, 1, 3);
    tv[3]  = mk(4'b1111, 1, 4'b0001, 1, 0);
    tv[4]  = mk(4'b1111, 1, 4'b0010, 1, 1);
    tv[5]  = mk(4'b1111, 1, 4'b0100, 1, 2);
    tv[6]  = mk(4'b1111, 1, 4'b1000, 1, 3);
    tv[7]  = mk(4'b1111, 1, 4'b0001, 1, 0);
    tv[8]  = mk(4'b1111, 1, 4'b0010, 1, 1);
    // stall three cycles, then refill at ptr=2
    tv[9]  = mk(4'b1111, 0, 4'b0000, 1, 1);
    tv[10] = mk(4'b1111, 0, 4'b0000, 1, 1);
    tv[11] = mk(4'b1111, 0, 4'b0000, 1, 1);
    tv[12] = mk(4'b1111, 1, 4'b0100, 1, 2);
    // ptr=3, only 0 and 1 valid: wrap and skip
    tv[13] = mk(4'b0011, 1, 4'b0001, 1, 0);
    tv[14] = mk(4'b0011, 1, 4'b0010, 1, 1);
    tv[15] = mk(4'b0011, 1, 4'b0001, 1, 0);
    tv[16] = mk(4'b0000, 1, 4'b0000, 0, 0);
    // empty stage grants even with the bank not ready
    tv[17] = mk(4'b0000, 0, 4'b0000, 0, 0);
    tv[18] = mk(4'b1000, 0, 4'b1000, 1, 3);
    tv[19] = mk(4'b0001, 0, 4'b0000, 1, 3);
    tv[20] = mk(4'b0000, 1, 4'b0000, 0, 3);

    rst = 1'b1;
    req_valid = 4'b1111;
    wr_ready = 1'b1;
    req_addr = '0;
    req_data = '0;
    load_tab();
    #12;
    chk("rst.rdy", 32'(req_ready), 32'h0);
    chk("rst.en", 32'(wr_en), 32'h0);
    chk("rst.addr", 32'(wr_addr), 32'h0);
    chk("rst.data", wr_data, 32'h0);
    chk("rst.id", 32'(wr_id), 32'h0);
    @(negedge clk);
    req_valid = 4'b0000;
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      req_valid = tv[i].v;
      wr_ready  = tv[i].wr;
      #1;
      chk($sformatf("v%0d.rdy", i),
          32'(req_ready), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), tv[i].en, tv[i].id);
    end

    // hold id=1 under stall, then async reset between edges
    @(negedge clk);
    req_valid = 4'b0010;
    wr_ready  = 1'b1;
    @(posedge clk); #1;
    chk_out("ar.load", 1'b1, 2'd1);
    @(negedge clk);
    req_valid = 4'b1111;
    wr_ready  = 1'b0;
    @(posedge clk); #1;
    chk_out("ar.stall", 1'b1, 2'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar.en", 32'(wr_en), 32'h0);
    chk("ar.rdy", 32'(req_ready), 32'h0);
    chk("ar.id", 32'(wr_id), 32'h0);
    chk("ar.data", wr_data, 32'h0);
    #1;
    rst = 1'b0;
    wr_ready = 1'b1;
    #1;
    chk("ar.first", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk_out("ar.post", 1'b1, 2'd0);

    // requester 3 back-to-back with data 1..5
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req_valid = 4'b1000;
      wr_ready  = 1'b1;
      req_data[3*32 +: 32] = 32'(k);
      #1;
      chk($sformatf("b2b%0d.rdy", k),
          32'(req_ready), 32'h8);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.en", k), 32'(wr_en), 32'h1);
      chk($sformatf("b2b%0d.id", k), 32'(wr_id), 32'h3);
      chk($sformatf("b2b%0d.data", k), wr_data, 32'(k));
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(posedge clk); #1;
    chk("b2b.drain", 32'(wr_en), 32'h0);
    chk("b2b.hold", wr_data, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wr_arb_rr.md
# reg_wr_arb_rr

Round-robin write arbiter that shares the single write port of a register bank among `REQ_NUM` requesters. Each requester presents an address/data pair with a valid/ready handshake. The arbiter grants one requester per cycle and registers the winning write into a one-entry output stage. The output stage holds the write stable until the bank accepts it. The block sits between the pipeline units and the register array, and is the only writer of that array.

## Interface
- `REQ_NUM`, 4, number of requesters; legal range 2..16
- `ADDR_WIDTH`, 5, register-bank address width
- `DATA_WIDTH`, 32, register data width
- `ID_WIDTH`, `$clog2(REQ_NUM)`, width of the requester index (derived; do not override)

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_req_valid`  in  `REQ_NUM`  bit k: requester k has a write pending
- `o_req_ready`  out  `REQ_NUM`  bit k: requester k's write is accepted this cycle (one-hot or zero)
- `i_req_addr`  in  `REQ_NUM*ADDR_WIDTH`  packed addresses; requester k occupies bits `[k*ADDR_WIDTH +: ADDR_WIDTH]`
- `i_req_data`  in  `REQ_NUM*DATA_WIDTH`  packed data; same packing as `i_req_addr`
- `i_wr_ready`  in  1  register bank accepts the presented write this cycle
- `o_wr_en`  out  1  output stage holds a valid write
- `o_wr_addr`  out  `ADDR_WIDTH`  write address
- `o_wr_data`  out  `DATA_WIDTH`  write data
- `o_wr_id`  out  `ID_WIDTH`  index of the requester that owns the held write

## Operation
- State: output stage (`o_wr_en`, `o_wr_addr`, `o_wr_data`, `o_wr_id`) plus round-robin pointer `ptr` (`ID_WIDTH` bits).
- The output stage is free when `!o_wr_en || i_wr_ready`.
- Winner selection:
  - The winner is the first k with `i_req_valid[k]=1`, searching k = `ptr`, `ptr+1`, ..., wrapping modulo `REQ_NUM`.
  - Selection is combinational from the current `i_req_valid` and `ptr`.
- Grant: `o_req_ready[winner]=1` only when a winner exists and the output stage is free. All other `o_req_ready` bits are 0.
- On a grant edge:
  - The output stage loads the winner's addr/data.
  - `o_wr_id` becomes the winner index and `o_wr_en` becomes 1.
  - `ptr` becomes `winner+1`, wrapping from `REQ_NUM-1` to 0.
- When `o_wr_en && i_wr_ready` and there is no grant: `o_wr_en` clears to 0 next edge. Addr, data and id keep their last values.
- When `o_wr_en && !i_wr_ready` (stall): all outputs hold, `o_req_ready=0`, `ptr` holds.
- Effective states:
  - EMPTY (`o_wr_en=0`): grant if any request.
  - FULL (`o_wr_en=1`): grant only with `i_wr_ready`, so drain and refill happen in the same edge.
- Requester rules:
  - A requester keeps addr/data stable while valid and not ready.
  - Withdrawing valid before ready is tolerated; the arbiter uses only the current-cycle inputs and does not check this.
- Fairness: a continuously asserted request is granted within `REQ_NUM` grants.
- Address 0 is an ordinary address; no filtering.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `o_wr_en=0`, `o_wr_addr=0`, `o_wr_data=0`, `o_wr_id=0`, `ptr=0`.
  - `o_req_ready=0` while `i_rst=1`.
- Reset mid-operation: a held write is dropped without being presented again. Requesters must re-request after reset.
- Latency: a request granted in cycle N appears on `o_wr_en/addr/data` in cycle N+1.
- Throughput: one write per cycle when `i_wr_ready` stays 1.
- `o_req_ready` depends combinationally on `i_req_valid`, `i_wr_ready` and state. There is no combinational path from the `addr`/`data` inputs to any output.
- Simultaneous drain and grant: in the same cycle, the bank accepts the old write and the new write loads. No bubble.

## Test plan
- Reset, then one request: after reset all outputs are 0. Requester 2 asserts valid with addr=5, data=0xDEADBEEF → `o_req_ready=4'b0100` in that cycle. Next cycle `o_wr_en=1`, addr=5, data=0xDEADBEEF, id=2, and `ptr` becomes 3.
- All four requesters valid continuously, `i_wr_ready=1`: grant order is 0,1,2,3,0,1, one grant per cycle, and `o_wr_id` follows the same sequence one cycle later.
- Stall: while a write is held, drive `i_wr_ready=0` for 3 cycles with all requests valid. Outputs stay stable and `o_req_ready=0` throughout. On the first cycle with `i_wr_ready=1`, a grant to `ptr` occurs in the same cycle.
- Wrap and skip: set `ptr`=3 (by granting requester 2 first), then only requesters 0 and 1 are valid → requester 0 is granted, then 1, then 0.
- Asynchronous reset mid-stall: hold a write with id=1 and `i_wr_ready=0`, then pulse `i_rst` between clock edges. `o_wr_en` drops to 0 before the next edge. After release, the first grant searches from requester 0.
- Single requester back-to-back: requester 3 valid for 5 cycles with incrementing data 1..5 and `i_wr_ready=1` → `o_wr_data` shows 1..5 on consecutive cycles with no bubbles.
